// File: rtl/sipo_deserializer_pkg.sv
// Shared types and helpers for the SIPO deserializer: counter width and
// the bit-count-derived state encoding.
package sipo_pkg;

   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_e;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial receive side plus valid/ready parallel side of the deserializer.
interface sipo_deserializer_if #(parameter int WIDTH = 4);
   logic             serial_in;
   logic             serial_valid;
   logic             frame_start;
   logic [WIDTH-1:0] parallel_out;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             overrun;

   modport master (
      output serial_in, serial_valid, frame_start, out_ready,
      input  parallel_out, out_valid, busy, overrun
   );

   modport slave (
      input  serial_in, serial_valid, frame_start, out_ready,
      output parallel_out, out_valid, busy, overrun
   );
endinterface

// File: rtl/sipo_out_buffer.sv
// One-word holding register with valid/ready output and overrun pulse.
module sipo_out_buffer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             out_ready,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   output logic             overrun
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (load) begin
         // A word can land if the slot is empty or being drained this cycle.
         if (!valid_q || out_ready) begin
            data_d  = load_data;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign parallel_out = data_q;
   assign out_valid    = valid_q;
   assign overrun      = ovr_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer: shift register, bit counter and frame
// resync in front of a one-word holding register.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input logic                clk,
   input logic                rst_n,
   sipo_deserializer_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] base_shift;
   logic [CW-1:0]    base_cnt;
   logic             load;
   state_e           state;

   assign state = (cnt_q == '0) ? IDLE : COLLECT;

   always_comb begin
      // frame_start restarts the word before this cycle's bit is considered
      base_shift = bus.frame_start ? '0 : shift_q;
      base_cnt   = bus.frame_start ? '0 : cnt_q;
      shift_d    = base_shift;
      cnt_d      = base_cnt;
      load       = 1'b0;
      if (bus.serial_valid) begin
         if (LSB_FIRST)
            shift_d = {bus.serial_in, base_shift[WIDTH-1:1]};
         else
            shift_d = {base_shift[WIDTH-2:0], bus.serial_in};
         if (base_cnt == CW'(WIDTH - 1)) begin
            load  = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = base_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.busy = (state == COLLECT);

   sipo_out_buffer #(.WIDTH(WIDTH)) u_out_buffer (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (load),
      .load_data    (shift_d),
      .out_ready    (bus.out_ready),
      .parallel_out (bus.parallel_out),
      .out_valid    (bus.out_valid),
      .overrun      (bus.overrun)
   );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: one LSB-first and one MSB-first DUT.
module tb_sipo_deserializer;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   bit   use_b = 1'b0;
   logic [3:0] sb_q[$];

   always #5 clk = ~clk;

   sipo_deserializer_if #(.WIDTH(4)) ia ();
   sipo_deserializer_if #(.WIDTH(4)) ib ();

   sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

   function automatic logic [3:0] po();  return use_b ? ib.parallel_out : ia.parallel_out; endfunction
   function automatic logic       ov();  return use_b ? ib.out_valid    : ia.out_valid;    endfunction
   function automatic logic       bsy(); return use_b ? ib.busy         : ia.busy;         endfunction
   function automatic logic       ovr(); return use_b ? ib.overrun      : ia.overrun;      endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ready(input logic r);
      if (use_b) ib.out_ready = r; else ia.out_ready = r;
   endtask

   task automatic send_bit(input logic b, input logic fs);
      if (use_b) begin
         ib.serial_in = b; ib.serial_valid = 1'b1; ib.frame_start = fs;
      end else begin
         ia.serial_in = b; ia.serial_valid = 1'b1; ia.frame_start = fs;
      end
      step();
      ia.serial_valid = 1'b0; ia.frame_start = 1'b0;
      ib.serial_valid = 1'b0; ib.frame_start = 1'b0;
   endtask

   task automatic send_bits(input logic [3:0] bits, input int n);
      // bits[0] is sent first
      for (int i = 0; i < n; i++) send_bit(bits[i], 1'b0);
   endtask

   task automatic check_head(input string name);
      checks++;
      if (sb_q.size() == 0) begin
         errors++; $display("FAIL %s scoreboard empty", name);
      end else if (ov() !== 1'b1 || po() !== sb_q[0]) begin
         errors++;
         $display("FAIL %s got valid=%b data=%h exp valid=1 data=%h", name, ov(), po(), sb_q[0]);
      end
   endtask

   task automatic consume(input string name);
      logic [3:0] exp;
      checks++;
      if (sb_q.size() == 0) begin
         errors++; $display("FAIL %s scoreboard empty", name);
      end else begin
         exp = sb_q.pop_front();
         if (ov() !== 1'b1 || po() !== exp) begin
            errors++;
            $display("FAIL %s got valid=%b data=%h exp valid=1 data=%h", name, ov(), po(), exp);
         end
      end
      set_ready(1'b1);
      step();
      set_ready(1'b0);
      checks++;
      if (ov() !== 1'b0) begin
         errors++; $display("FAIL %s_drop got valid=%b exp 0", name, ov());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      checks++;
      if (ia.parallel_out !== 4'h0 || ia.out_valid !== 1'b0 || ia.busy !== 1'b0 || ia.overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset got po=%h v=%b busy=%b ovr=%b exp 0 0 0 0",
                  ia.parallel_out, ia.out_valid, ia.busy, ia.overrun);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      send_bit(1'b1, 1'b0);
      checks++;
      if (bsy() !== 1'b1) begin errors++; $display("FAIL busy_mid got %b exp 1", bsy()); end
      send_bits(4'b1101 >> 1, 3);   // remaining bits 0,1,1
      sb_q.push_back(4'hD);
      check_head("basic_word");
      checks++;
      if (bsy() !== 1'b0) begin errors++; $display("FAIL busy_done got %b exp 0", bsy()); end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 10; i++) begin
         step();
         check_head("hold_stable");
      end
      consume("hold_consume");
   endtask

   task automatic test_back_to_back();
      send_bits(4'h3, 4);
      sb_q.push_back(4'h3);
      check_head("b2b_first");
      send_bits(4'hA, 3);
      // handshake of 3 coincides with completion of A
      checks++;
      if (po() !== 4'h3) begin errors++; $display("FAIL b2b_pre got %h exp 3", po()); end
      void'(sb_q.pop_front());
      sb_q.push_back(4'hA);
      set_ready(1'b1);
      send_bit(1'b1, 1'b0);
      set_ready(1'b0);
      check_head("b2b_second");
      consume("b2b_consume");
   endtask

   task automatic test_overrun();
      send_bits(4'h5, 4);
      sb_q.push_back(4'h5);
      checks++;
      if (ovr() !== 1'b0) begin errors++; $display("FAIL ovr_idle got %b exp 0", ovr()); end
      send_bits(4'hF, 4);
      checks++;
      if (ovr() !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b exp 1", ovr()); end
      check_head("ovr_keep");
      step();
      checks++;
      if (ovr() !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle got %b exp 0", ovr()); end
      consume("ovr_consume");
   endtask

   task automatic test_frame();
      send_bits(4'b0001, 2);
      send_bit(1'b1, 1'b1);
      checks++;
      if (bsy() !== 1'b1) begin errors++; $display("FAIL frame_busy got %b exp 1", bsy()); end
      send_bits(4'b0011, 2);
      checks++;
      if (ov() !== 1'b0) begin errors++; $display("FAIL frame_early got valid=%b exp 0", ov()); end
      send_bit(1'b0, 1'b0);
      sb_q.push_back(4'h7);
      check_head("frame_word");
      consume("frame_consume");
   endtask

   task automatic test_msb_and_reset();
      use_b = 1'b1;
      send_bits(4'b0001, 4);   // bits 1,0,0,0 MSB-first
      sb_q.push_back(4'h8);
      check_head("msb_word");
      consume("msb_consume");
      use_b = 1'b0;
      send_bits(4'h6, 4);     // left pending, then lost to reset
      send_bits(4'b0011, 2);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ia.parallel_out !== 4'h0 || ia.out_valid !== 1'b0 || ia.busy !== 1'b0 || ia.overrun !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got po=%h v=%b busy=%b ovr=%b exp 0 0 0 0",
                  ia.parallel_out, ia.out_valid, ia.busy, ia.overrun);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_bits(4'h9, 3);
      checks++;
      if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_early got %b exp 0", ia.out_valid); end
      send_bit(1'b1, 1'b0);
      sb_q.push_back(4'h9);
      checks++;
      if (ia.overrun !== 1'b0) begin errors++; $display("FAIL post_reset_ovr got %b exp 0", ia.overrun); end
      check_head("post_reset_word");
      consume("post_reset_consume");
   endtask

   initial begin
      rst_n = 1'b0;
      ia.serial_in = 1'b0; ia.serial_valid = 1'b0; ia.frame_start = 1'b0; ia.out_ready = 1'b0;
      ib.serial_in = 1'b0; ib.serial_valid = 1'b0; ib.frame_start = 1'b0; ib.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_back_to_back();
      test_overrun();
      test_frame();
      test_msb_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
